// File: rtl/gray_arb_pkg.sv
// Shared types and reference helpers for the Gray conversion arbiter.
package gray_arb_pkg;

  // Occupancy of the single output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } gray_arb_state_e;

  localparam int GRAY_ARB_REF_W = 32;

  // Reference binary-to-Gray conversion; callers truncate to their width.
  function automatic logic [GRAY_ARB_REF_W-1:0] bin2gray(input logic [GRAY_ARB_REF_W-1:0] bin);
    return bin ^ (bin >> 32'd1);
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Purely combinational binary-to-Gray converter built from bit-level gates.
module bin2gray_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o
);

  // The MSB passes straight through; a buffer keeps the structure gate-level.
  buf u_msb (o[WIDTH-1], i[WIDTH-1]);

  // Every lower bit is the xor of itself and its upper neighbour.
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_bit
    xor u_x (o[k], i[k+1], i[k]);
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary-to-Gray stage between
// N_REQ requesters, with a valid/ready output register tagged by requester id.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] bin_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       gray_out,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_valid,
  input  logic                   out_ready
);

  // Adds an offset to a requester index, wrapping modulo N_REQ (handles
  // non-power-of-two requester counts).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  gray_arb_state_e   r_state;
  logic              r_valid;
  logic [WIDTH-1:0]  r_gray;
  logic [ID_W-1:0]   r_out_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_can_load;
  logic              w_found;
  logic              w_grant;
  logic [ID_W-1:0]   w_cand;
  logic [ID_W-1:0]   w_win_id;
  logic [ID_W-1:0]   w_ptr_next;
  logic [N_REQ-1:0]  w_gnt;
  logic [WIDTH-1:0]  w_sel_bin;
  logic [WIDTH-1:0]  w_sel_gray;

  // The register may take a new value when empty or when its content leaves now.
  assign w_can_load = (r_state == EMPTY) || out_ready;

  // Rotating-priority scan: first set request at or above r_ptr, wrapping to 0.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = wrap_add(r_ptr, k);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_win_id = w_cand;
      end else begin
        w_win_id = w_win_id;
      end
    end
  end

  // A grant needs a winner and room in the register; reset voids it at once.
  assign w_grant    = rst_n && w_can_load && w_found;
  assign w_ptr_next = wrap_add(w_win_id, 1);

  // One-hot grant vector, all zero when no grant is issued.
  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant && (w_win_id == ID_W'(k))) begin
        w_gnt[k] = 1'b1;
      end else begin
        w_gnt[k] = 1'b0;
      end
    end
  end

  // Operand mux: select the winning requester's slice.
  assign w_sel_bin = bin_in[int'(w_win_id)*WIDTH +: WIDTH];

  bin2gray_n #(
    .WIDTH (WIDTH)
  ) u_conv (
    .i (w_sel_bin),
    .o (w_sel_gray)
  );

  // Output-register FSM: loads on grant, drains on accept, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_valid  <= 1'b0;
      r_gray   <= '0;
      r_out_id <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_grant) begin
            r_state  <= FULL;
            r_valid  <= 1'b1;
            r_gray   <= w_sel_gray;
            r_out_id <= w_win_id;
            r_ptr    <= w_ptr_next;
          end else begin
            r_state  <= EMPTY;
            r_valid  <= 1'b0;
          end
        end
        FULL: begin
          if (w_grant) begin
            // Accept and reload in the same edge: back-to-back, no bubble.
            r_state  <= FULL;
            r_valid  <= 1'b1;
            r_gray   <= w_sel_gray;
            r_out_id <= w_win_id;
            r_ptr    <= w_ptr_next;
          end else if (out_ready) begin
            // Drained with nothing to replace it; data bits keep last value.
            r_state  <= EMPTY;
            r_valid  <= 1'b0;
          end else begin
            r_state  <= FULL;
            r_valid  <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = w_gnt;
  assign gray_out  = r_gray;
  assign out_id    = r_out_id;
  assign out_valid = r_valid;

endmodule
